// File: rtl/expr_seq_pkg.sv
// Shared definitions for the RPN expression sequencer.
// Holds the ALU opcodes the sequencer drives and the sequencer's own
// instruction opcodes. It also holds the error codes, the FSM state
// enum and the instruction-width helper.
package expr_seq_pkg;

    // Opcodes understood by the stack ALU
    localparam logic [2:0] ALU_NOP  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_PUSH = 3'b110;

    // Sequencer instruction opcodes (top three bits of a program word)
    localparam logic [2:0] OP_HALT      = 3'b000;
    localparam logic [2:0] OP_PUSH_IMM  = 3'b001;
    localparam logic [2:0] OP_PUSH_RES  = 3'b010;
    localparam logic [2:0] OP_PUSH_LAST = 3'b011;
    localparam logic [2:0] OP_ADD       = 3'b100;
    localparam logic [2:0] OP_MUL       = 3'b101;
    localparam logic [2:0] OP_STORE     = 3'b110;
    localparam logic [2:0] OP_RSVD      = 3'b111;

    // Run status reported on err
    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
    localparam logic [1:0] ERR_FULL      = 2'b10;
    localparam logic [1:0] ERR_PC_END    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_ISSUE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // An instruction word is {op[2:0], ridx, imm}
    function automatic int instr_w(input int n, input int ridx_w);
        return 3 + ridx_w + n;
    endfunction

endpackage

// File: rtl/expr_prog_ram.sv
// Program memory for the expression sequencer.
// Writes are synchronous and reads are asynchronous, so the sequencer can
// decode prog[pc] in the same cycle that pc is presented.
// Ports:
//   clk   - write clock
//   we    - write strobe (already gated against busy by the parent)
//   waddr - write address
//   wdata - instruction word to store
//   raddr - read address (the program counter)
//   rdata - instruction word at raddr, combinational
module expr_prog_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 21,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents survive reset on purpose, so a program can be rerun after an abort
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/expr_sequencer.sv
// Start/done engine that runs a small RPN program against a stack ALU.
// The program lives in local RAM. Each instruction becomes a PUSH, ADD or
// MUL presented to the ALU, and arithmetic results are captured into
// "last". From "last" they can be stored into a small result file or
// pushed back.
// Ports:
//   clk, rst          - clock and asynchronous active-low reset
//   prog_we/addr/wdata - program RAM write port (dropped while busy)
//   start             - begin a run at pc=0 when idle
//   busy, done        - run in progress / one-cycle end-of-run pulse
//   err               - 00 ok, 01 underflow, 10 stack full, 11 pc ran off end
//   ovf_flag          - sticky ALU overflow seen during the run
//   res_sel, res_data - combinational read of the result register file
//   alu_rst           - active-high ALU reset
//   alu_opcode/data   - registered command to the ALU
//   alu_output_data   - ALU result
//   alu_overflow      - ALU overflow flag
module expr_sequencer
    import expr_seq_pkg::*;
#(
    parameter int N          = 16,
    parameter int STACK_SIZE = 16,
    parameter int PROG_DEPTH = 32,
    parameter int NUM_RES    = 4,
    localparam int RIDX_W    = $clog2(NUM_RES),
    localparam int PC_W      = $clog2(PROG_DEPTH),
    localparam int INSTR_W   = instr_w(N, RIDX_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err,
    output logic               ovf_flag,
    input  logic [RIDX_W-1:0]  res_sel,
    output logic [N-1:0]       res_data,
    output logic               alu_rst,
    output logic [2:0]         alu_opcode,
    output logic [N-1:0]       alu_data,
    input  logic [N-1:0]       alu_output_data,
    input  logic               alu_overflow
);

    localparam int DEPTH_W = $clog2(STACK_SIZE + 1);

    state_t              state, state_next;
    logic [PC_W-1:0]     pc;
    logic                wrapped;
    logic [DEPTH_W-1:0]  depth;
    logic [N-1:0]        last;
    logic [N-1:0]        res [NUM_RES];

    logic [INSTR_W-1:0]  instr;
    logic [2:0]          op;
    logic [RIDX_W-1:0]   ridx;
    logic [N-1:0]        imm;

    logic                load_issue;
    logic [2:0]          issue_opcode;
    logic [N-1:0]        issue_data;
    logic                set_err;
    logic [1:0]          err_code;
    logic                do_store;

    expr_prog_ram #(.DEPTH(PROG_DEPTH), .WIDTH(INSTR_W)) u_prog_ram (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc),
        .rdata (instr)
    );

    assign op   = instr[INSTR_W-1 -: 3];
    assign ridx = instr[N +: RIDX_W];
    assign imm  = instr[N-1:0];

    assign busy     = (state == ST_CLEAR) || (state == ST_FETCH) ||
                      (state == ST_ISSUE) || (state == ST_CAPTURE);
    assign done     = (state == ST_DONE);
    assign alu_rst  = !rst || (state == ST_CLEAR);
    assign res_data = res[res_sel];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and fetch decode. Error checks come before any issue, so a
    // faulting op never reaches alu_opcode.
    always_comb begin
        state_next   = state;
        load_issue   = 1'b0;
        issue_opcode = ALU_NOP;
        issue_data   = '0;
        set_err      = 1'b0;
        err_code     = ERR_OK;
        do_store     = 1'b0;
        case (state)
            ST_IDLE:    if (start) state_next = ST_CLEAR;
            ST_CLEAR:   state_next = ST_FETCH;
            ST_FETCH: begin
                if (wrapped) begin
                    set_err    = 1'b1;
                    err_code   = ERR_PC_END;
                    state_next = ST_DONE;
                end else begin
                    case (op)
                        OP_PUSH_IMM, OP_PUSH_RES, OP_PUSH_LAST: begin
                            if (depth == DEPTH_W'(STACK_SIZE)) begin
                                set_err    = 1'b1;
                                err_code   = ERR_FULL;
                                state_next = ST_DONE;
                            end else begin
                                load_issue   = 1'b1;
                                issue_opcode = ALU_PUSH;
                                issue_data   = (op == OP_PUSH_IMM) ? imm :
                                               (op == OP_PUSH_RES) ? res[ridx] : last;
                                state_next   = ST_ISSUE;
                            end
                        end
                        OP_ADD, OP_MUL: begin
                            if (depth < DEPTH_W'(2)) begin
                                set_err    = 1'b1;
                                err_code   = ERR_UNDERFLOW;
                                state_next = ST_DONE;
                            end else begin
                                load_issue   = 1'b1;
                                issue_opcode = (op == OP_ADD) ? ALU_ADD : ALU_MUL;
                                state_next   = ST_ISSUE;
                            end
                        end
                        OP_STORE: do_store = 1'b1;
                        default:  state_next = ST_DONE;
                    endcase
                end
            end
            ST_ISSUE:   state_next = (alu_opcode == ALU_PUSH) ? ST_FETCH : ST_CAPTURE;
            ST_CAPTURE: state_next = ST_FETCH;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Datapath: pc, depth, result file and the registered ALU command. The
    // opcode falls back to NOP on every edge that does not load an issue, so
    // it is non-NOP only during ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= '0;
            wrapped    <= 1'b0;
            depth      <= '0;
            err        <= ERR_OK;
            ovf_flag   <= 1'b0;
            last       <= '0;
            alu_opcode <= ALU_NOP;
            alu_data   <= '0;
            for (int i = 0; i < NUM_RES; i++) begin
                res[i] <= '0;
            end
        end else begin
            alu_opcode <= load_issue ? issue_opcode : ALU_NOP;
            if (load_issue) begin
                alu_data <= issue_data;
            end
            case (state)
                ST_CLEAR: begin
                    pc       <= '0;
                    wrapped  <= 1'b0;
                    depth    <= '0;
                    err      <= ERR_OK;
                    ovf_flag <= 1'b0;
                end
                ST_FETCH: begin
                    pc <= pc + PC_W'(1);
                    if (pc == PC_W'(PROG_DEPTH - 1)) begin
                        wrapped <= 1'b1;
                    end
                    if (set_err) begin
                        err <= err_code;
                    end
                    if (do_store) begin
                        res[ridx] <= last;
                    end
                end
                ST_ISSUE: begin
                    if (alu_opcode == ALU_PUSH) begin
                        depth <= depth + DEPTH_W'(1);
                    end else begin
                        depth <= depth - DEPTH_W'(2);
                    end
                end
                ST_CAPTURE: begin
                    last     <= alu_output_data;
                    ovf_flag <= ovf_flag | alu_overflow;
                end
                default: ;
            endcase
        end
    end

endmodule
